// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the continuous monitoring system.
// Trace items are packed MSB..LSB as {ovf, delta, pc, instr}.
package continuous_monitoring_system_pkg;

    localparam int RISC_V_INSTRUCTION_WIDTH = 32;
    localparam int DEFAULT_PC_WIDTH         = 64;
    localparam int DEFAULT_DELTA_WIDTH      = 16;
    localparam int DEFAULT_TRACE_DEPTH      = 16;

    localparam int TRACE_ITEM_WIDTH =
        1 + DEFAULT_DELTA_WIDTH + DEFAULT_PC_WIDTH + RISC_V_INSTRUCTION_WIDTH;

    typedef struct packed {
        logic                                ovf;
        logic [DEFAULT_DELTA_WIDTH-1:0]      delta;
        logic [DEFAULT_PC_WIDTH-1:0]         pc;
        logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
    } trace_item_t;

    // Item width for non-default pc/delta widths; matches TRACE_ITEM_WIDTH at defaults.
    function automatic int trace_item_width(input int pc_w, input int delta_w);
        return 1 + delta_w + pc_w + RISC_V_INSTRUCTION_WIDTH;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output; a push into an empty FIFO
// is visible on pop_data one cycle later.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_next;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = head_q;

    always_comb begin
        pop_ok     = pop & ~empty;
        push_ok    = push & (~full | pop_ok);
        rd_next    = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count_q + CW'(push_ok) - CW'(pop_ok);
        // The new head may be the word being written this very cycle.
        if (push_ok && (wr_ptr == rd_next)) begin
            head_next = push_data;
        end else begin
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_next;
            count_q <= count_next;
            if (count_next != '0) begin
                head_q <= head_next;
            end
        end
    end

endmodule

// File: rtl/trace_item_buffer.sv
// Captures retired {pc, instr} with a saturating cycle delta into trace items,
// buffers them for a valid/ready consumer and counts items lost to overflow.
module trace_item_buffer
    import continuous_monitoring_system_pkg::*;
#(
    parameter  int PC_WIDTH           = DEFAULT_PC_WIDTH,
    parameter  int DEPTH              = DEFAULT_TRACE_DEPTH,
    parameter  int DELTA_WIDTH        = DEFAULT_DELTA_WIDTH,
    parameter  int ALMOST_FULL_MARGIN = 2,
    parameter  int OVF_CNT_WIDTH      = 32,
    localparam int ITEM_W             = trace_item_width(PC_WIDTH, DELTA_WIDTH),
    localparam int CNT_W              = $clog2(DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                pc_valid,
    input  logic [PC_WIDTH-1:0]                 pc,
    input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr,
    input  logic                                drop_instr,
    output logic [ITEM_W-1:0]                   m_tdata,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [CNT_W-1:0]                    occupancy,
    output logic                                almost_full,
    output logic [OVF_CNT_WIDTH-1:0]            overflow_count
);

    localparam logic [DELTA_WIDTH-1:0]   DELTA_MAX = '1;
    localparam logic [OVF_CNT_WIDTH-1:0] OVF_MAX   = '1;
    localparam logic [CNT_W-1:0]         AF_LEVEL  = CNT_W'(DEPTH - ALMOST_FULL_MARGIN);

    logic                   cap;
    logic                   pop;
    logic                   push;
    logic                   lost;
    logic                   full;
    logic                   empty;
    logic [CNT_W-1:0]       count_next;
    logic [ITEM_W-1:0]      item;
    logic [DELTA_WIDTH-1:0] delta_q;
    logic                   pending_ovf;
    logic                   almost_full_q;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q;

    assign cap        = enable & pc_valid & ~drop_instr;
    assign pop        = m_tvalid & m_tready;
    assign push       = cap & (~full | pop);
    assign lost       = cap & full & ~pop;
    assign count_next = occupancy + CNT_W'(push) - CNT_W'(pop);
    assign item       = {pending_ovf, delta_q, pc, instr};

    assign m_tvalid       = ~empty;
    assign almost_full    = almost_full_q;
    assign overflow_count = ovf_cnt_q;

    sync_fifo #(
        .WIDTH (ITEM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (item),
        .pop       (pop),
        .pop_data  (m_tdata),
        .full      (full),
        .empty     (empty),
        .count     (occupancy)
    );

    // Lost items do not restart the delta; the next stored item spans them.
    always_ff @(posedge clk) begin
        if (rst) begin
            delta_q       <= '0;
            pending_ovf   <= 1'b0;
            ovf_cnt_q     <= '0;
            almost_full_q <= 1'b0;
        end else begin
            if (push) begin
                delta_q <= DELTA_WIDTH'(1);
            end else if (delta_q != DELTA_MAX) begin
                delta_q <= delta_q + DELTA_WIDTH'(1);
            end

            if (push) begin
                pending_ovf <= 1'b0;
            end else if (lost) begin
                pending_ovf <= 1'b1;
            end

            if (lost && (ovf_cnt_q != OVF_MAX)) begin
                ovf_cnt_q <= ovf_cnt_q + OVF_CNT_WIDTH'(1);
            end

            almost_full_q <= (count_next >= AF_LEVEL);
        end
    end

endmodule

// File: tb/tb_trace_item_buffer.sv
// Bench for trace_item_buffer: directed and random stimulus against a queue model
// where delta is the cycle distance to the previous stored item (or reset).
module tb_trace_item_buffer;

    localparam int PCW = 64;
    localparam int DEP = 16;
    localparam int DW  = 4;
    localparam int AFM = 2;
    localparam int OW  = 4;
    localparam int IW  = 1 + DW + PCW + 32;
    localparam int CW  = $clog2(DEP) + 1;
    localparam int DMAX = (1 << DW) - 1;
    localparam int OMAX = (1 << OW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           pc_valid = 1'b0;
    logic [PCW-1:0] pc = '0;
    logic [31:0]    instr = '0;
    logic           drop_instr = 1'b0;
    logic           m_tready = 1'b0;
    logic [IW-1:0]  m_tdata;
    logic           m_tvalid;
    logic [CW-1:0]  occupancy;
    logic           almost_full;
    logic [OW-1:0]  overflow_count;

    always #5 clk = ~clk;

    trace_item_buffer #(
        .PC_WIDTH           (PCW),
        .DEPTH              (DEP),
        .DELTA_WIDTH        (DW),
        .ALMOST_FULL_MARGIN (AFM),
        .OVF_CNT_WIDTH      (OW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .instr          (instr),
        .drop_instr     (drop_instr),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .occupancy      (occupancy),
        .almost_full    (almost_full),
        .overflow_count (overflow_count)
    );

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] q[$];
    int cyc = 0;
    int last_store = 0;
    bit pend = 1'b0;
    int lost_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs now applied, then compare.
    task automatic step();
        bit cap, pop, push, lost;
        int d;
        if (rst) begin
            q.delete();
            pend = 1'b0;
            lost_cnt = 0;
            last_store = cyc + 1;
        end else begin
            cap  = enable && pc_valid && !drop_instr;
            pop  = (q.size() != 0) && m_tready;
            push = cap && (q.size() < DEP || pop);
            lost = cap && (q.size() == DEP) && !pop;
            d = cyc - last_store;
            if (d > DMAX) d = DMAX;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({pend, DW'(d), pc, instr});
                pend = 1'b0;
                last_store = cyc;
            end
            if (lost) begin
                pend = 1'b1;
                if (lost_cnt < OMAX) lost_cnt++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("m_tvalid", m_tvalid, q.size() != 0);
        chk("occupancy", occupancy, q.size());
        chk("almost_full", almost_full, q.size() >= DEP - AFM);
        chk("overflow_count", overflow_count, lost_cnt);
        if (q.size() != 0) chk("m_tdata", m_tdata, q[0]);
    endtask

    task automatic capture(input logic [PCW-1:0] p, input logic [31:0] ins);
        enable = 1'b1; pc_valid = 1'b1; drop_instr = 1'b0; pc = p; instr = ins;
        step();
        pc_valid = 1'b0;
    endtask

    task automatic drain();
        m_tready = 1'b1; pc_valid = 1'b0;
        for (int i = 0; i < 3 * DEP && m_tvalid; i++) step();
        chk("drain_done", m_tvalid, 1'b0);
        m_tready = 1'b0;
    endtask

    logic [IW-1:0] first_item;

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_tdata", m_tdata, '0);
        chk("rst_occ", occupancy, 0);

        // Single capture straight after reset
        capture(64'h8000_0000, 32'h0000_0013);
        first_item = {1'b0, 4'd0, 64'h8000_0000, 32'h0000_0013};
        chk("first_item", m_tdata, first_item);

        // Filtered instructions are not recorded
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1; pc_valid = 1'b1; drop_instr = 1'b1;
            pc = 64'h8000_0004 + 64'(4 * i); instr = 32'h0000_0033;
            step();
        end
        drop_instr = 1'b0;
        capture(64'h8000_0010, 32'h0010_0093);
        chk("drop_occ", occupancy, 2);
        drain();

        // Fill past full with the consumer stalled
        for (int i = 0; i < DEP + 2; i++) capture({$urandom, $urandom}, $urandom);
        chk("fill_occ", occupancy, DEP);
        chk("fill_ovf", overflow_count, 2);

        // Push and pop together at full, then drain in order
        m_tready = 1'b1;
        capture(64'h0000_0000_CAFE_0000, 32'h1234_5678);
        chk("full_pp_occ", occupancy, DEP);
        chk("full_pp_ovf", overflow_count, 2);
        drain();

        // Delta saturates across a long idle gap
        capture(64'h1000, 32'h13);
        for (int i = 0; i < 20; i++) step();
        capture(64'h1004, 32'h13);
        m_tready = 1'b1; step(); m_tready = 1'b0;
        chk("sat_delta", m_tdata[IW-2 -: DW], DMAX);
        drain();

        // Overflow counter saturates
        for (int i = 0; i < DEP + 20; i++) capture({$urandom, $urandom}, $urandom);
        chk("ovf_sat", overflow_count, OMAX);
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            pc_valid   = ($urandom_range(0, 3) != 0);
            drop_instr = ($urandom_range(0, 4) == 0);
            m_tready   = ($urandom_range(0, 2) == 0);
            pc         = {$urandom, $urandom};
            instr      = $urandom;
            step();
        end
        enable = 1'b1;
        drain();

        // Reset with items buffered
        for (int i = 0; i < 5; i++) capture({$urandom, $urandom}, $urandom);
        chk("pre_rst_occ", occupancy, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", m_tvalid, 1'b0);
        chk("rst_mid_occ", occupancy, 0);
        chk("rst_mid_ovf", overflow_count, 0);
        chk("rst_mid_tdata", m_tdata, '0);
        capture(64'h2000, 32'h0000_0013);
        chk("post_rst_delta", m_tdata[IW-2 -: DW], 0);
        chk("post_rst_ovf_bit", m_tdata[IW-1], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
